pnp_scanner: RTL and testbench
==============================

// Module: pnp_scanner
// PURPOSE
//  APB initiator that reads the plug-n-play descriptor table held by the pnp slave.
//  Rebuilds each 16-byte descriptor and searches for the Nth device matching a requested vid/did.
//  Returns that device's base/end address and slot index to boot or bring-up logic.
//  Bridge-side peer of the pnp slave; sits on the APB segment behind the AXI2APB bridge.
// PARAMETERS
//  TABLE_BASE  32'h000FF000  APB byte address of descriptor slot 0
//  MAX_DEV     16            slots scanned; equals SOC_PNP_TOTAL; range 1..32
//  TIMEOUT     255           PREADY wait limit in cycles; used only with PNP_SCAN_TIMEOUT_EN
// PORTS
//  i_clk          in   1   system clock
//  i_nrst         in   1   asynchronous reset, active-low
//  i_start        in   1   scan request; sampled in IDLE only
//  i_vid          in   16  vendor ID to match
//  i_did          in   16  device ID to match
//  i_inst         in   4   match instance: 0 = first match, 1 = second, ...
//  o_busy         out  1   scan in progress
//  o_done         out  1   one-cycle pulse at scan end
//  o_found        out  1   match found; valid from o_done until next start
//  o_err          out  1   APB error or timeout; valid from o_done until next start
//  o_index        out  5   slot index of the match
//  o_addr_start   out  32  addr_start[31:0] of the match
//  o_addr_end     out  32  addr_end[31:0] of the match
//  o_psel         out  1   APB select
//  o_penable      out  1   APB enable
//  o_paddr        out  32  APB address
//  o_pwrite       out  1   tied to 0; read-only initiator
//  i_pready       in   1   APB ready
//  i_prdata       in   32  APB read data
//  i_pslverr      in   1   APB slave error
// BEHAVIOUR
//  Reset: every output is 0 and the FSM is in IDLE.
//  Reset is async and may assert mid-scan: the APB transfer is abandoned and no o_done pulse is produced.
//  Descriptor layout at TABLE_BASE + 16*slot:
//    +0x0: [9:8] descrtype, [7:0] descrsize
//    +0x4: [31:16] vid, [15:0] did
//    +0x8: addr_start[31:0]
//    +0xC: addr_end[31:0]
//  FSM states: IDLE, SETUP, ACCESS, CHECK, DONE.
//  IDLE: if i_start=1, latch vid/did/inst, clear found/err/match count, set slot=0 and word=0, go to SETUP.
//    o_busy is 1 from the next cycle.
//  SETUP: psel=1, penable=0, paddr=TABLE_BASE+{slot,word,2'b00}. Go to ACCESS.
//  ACCESS: psel=1, penable=1, held until i_pready=1. Zero wait states means 2 cycles per read.
//    With pready: capture prdata into the word register; pslverr=1 sets err and goes to DONE.
//    Otherwise word=3 goes to CHECK; else word+1 and back to SETUP.
//  CHECK (1 cycle):
//    descrtype==INVALID or descrsize==0 ends the table: go to DONE, found=0.
//    vid/did match with count==inst: found=1, load index/addr outputs, go to DONE.
//    vid/did match with count!=inst: count+1, continue.
//    Continue means: slot==MAX_DEV-1 goes to DONE (found=0); else slot+1, word=0, SETUP.
//  DONE: o_done=1 for one cycle, o_busy=0, return to IDLE.
//  i_start is ignored while busy and in DONE.
//  Outputs hold until the next accepted start.
//  Fixed latency with zero waits: 9 cycles per scanned slot, plus 2 cycles (start accept, DONE).
//  Counters: slot is 5 bits and count is 4 bits; both wrap-free thanks to MAX_DEV and inst limits.
//  The descriptor's 64-bit addresses are truncated to their low 32 bits.
// CONFIGURATION
//  PNP_SCAN_TIMEOUT_EN defined:
//    An 8-bit counter runs in ACCESS and is cleared on every SETUP.
//    Reaching TIMEOUT without pready sets err, drops psel/penable, and goes to DONE.
//  PNP_SCAN_TIMEOUT_EN undefined:
//    No counter; ACCESS waits indefinitely for i_pready.
// STRUCTURE
//  types_pnp_pkg gains:
//    PNP_DESCR_OFF_TYPE=0, _ID=4, _START=8, _END=12
//    a pnp_scan_state_type enum
//  Sub-module pnp_apb_rd is the single-read APB engine:
//    req/addr in; rdata/err/ack out; it owns the timeout counter.
//  pnp_scanner keeps the slot/word walk, the match logic and the outputs.
// TESTING
//  1. Table of 16 valid slots; slot 5 holds vid=00F2, did=007A, 0x10010000..0x10010FFF; request inst=0.
//     -> o_done after 56 cycles; found=1; index=5; addr_start=0x10010000; addr_end=0x10010FFF.
//  2. Slots 3 and 9 both hold did 007A; request inst=1.
//     -> index=9; the match count skips slot 3.
//  3. Slot 4 has descrtype=0.
//     -> scan stops at slot 4 with found=0 and err=0; no APB access to slot 5 (0x50 offset).
//  4. pslverr=1 on the read of slot 2, +0x8.
//     -> err=1, found=0, o_done pulse; psel=0 on the next cycle.
//  5. i_nrst pulsed low during ACCESS of slot 7.
//     -> all outputs 0 immediately; no o_done; a new start runs from slot 0.
//  6. With PNP_SCAN_TIMEOUT_EN, TIMEOUT=8, and pready held low.
//     -> err=1 after 8 ACCESS cycles; without the macro, psel stays high for 1000 cycles.

Source files
------------

// File: rtl/types_pnp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : types_pnp_pkg                                                     |
// | Brief   : Descriptor offsets, scanner state type and address helper for     |
// |           the plug-n-play table scanner.                                    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package types_pnp_pkg;

    localparam logic [3:0] PNP_DESCR_OFF_TYPE  = 4'd0;
    localparam logic [3:0] PNP_DESCR_OFF_ID    = 4'd4;
    localparam logic [3:0] PNP_DESCR_OFF_START = 4'd8;
    localparam logic [3:0] PNP_DESCR_OFF_END   = 4'd12;

    localparam logic [1:0] PNP_DESCR_INVALID   = 2'd0;

    typedef enum logic [2:0] {
        PNP_SCAN_IDLE   = 3'd0,
        PNP_SCAN_SETUP  = 3'd1,
        PNP_SCAN_ACCESS = 3'd2,
        PNP_SCAN_CHECK  = 3'd3,
        PNP_SCAN_DONE   = 3'd4
    } pnp_scan_state_type;

    // Each slot is 16 bytes; word selects one of its four 32-bit fields.
    function automatic logic [31:0] pnp_descr_addr(input logic [31:0] base,
                                                   input logic [4:0]  slot,
                                                   input logic [1:0]  word);
        return base + {23'd0, slot, word, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pnp_apb_rd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pnp_apb_rd                                                         |
// | Brief  : Single-read APB engine. Holding i_req gives SETUP then ACCESS;     |
// |          o_ack pulses when the read completes. With PNP_SCAN_TIMEOUT_EN     |
// |          an ACCESS lasting TIMEOUT cycles without PREADY ends in an error.  |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module pnp_apb_rd #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_psel,
    output logic        o_penable,
    output logic [31:0] o_paddr,
    input  logic        i_pready,
    input  logic [31:0] i_prdata,
    input  logic        i_pslverr
);

    logic r_access;
    logic w_timeout;

`ifdef PNP_SCAN_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_timer;

    // Cleared in every SETUP phase, counts stalled ACCESS cycles.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_timer <= 8'd0;
        end else if (!r_access) begin
            r_timer <= 8'd0;
        end else if (!i_pready) begin
            r_timer <= r_timer + 8'd1;
        end
    end

    assign w_timeout = r_access && !i_pready && (r_timer == c_TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_access <= 1'b0;
        end else begin
            r_access <= i_req && (!r_access || !o_ack);
        end
    end

    assign o_ack     = r_access && (i_pready || w_timeout);
    assign o_err     = r_access && ((i_pready && i_pslverr) || w_timeout);
    assign o_rdata   = i_prdata;
    assign o_psel    = i_req;
    assign o_penable = i_req && r_access;
    assign o_paddr   = i_req ? i_addr : 32'd0;

endmodule
`default_nettype wire

// File: rtl/pnp_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pnp_scanner                                                        |
// | Brief  : Walks the pnp descriptor table over APB and reports the Nth slot   |
// |          matching vid/did. PNP_SCAN_TIMEOUT_EN enables the PREADY timeout.  |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module pnp_scanner
    import types_pnp_pkg::*;
#(
    parameter logic [31:0] TABLE_BASE = 32'h000FF000,
    parameter int          MAX_DEV    = 16,
    parameter int          TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_start,
    input  logic [15:0] i_vid,
    input  logic [15:0] i_did,
    input  logic [3:0]  i_inst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_found,
    output logic        o_err,
    output logic [4:0]  o_index,
    output logic [31:0] o_addr_start,
    output logic [31:0] o_addr_end,
    output logic        o_psel,
    output logic        o_penable,
    output logic [31:0] o_paddr,
    output logic        o_pwrite,
    input  logic        i_pready,
    input  logic [31:0] i_prdata,
    input  logic        i_pslverr
);

    localparam logic [4:0] c_LAST_SLOT = 5'(MAX_DEV - 1);

    pnp_scan_state_type r_state, w_next;

    logic [15:0] r_vid, r_did;
    logic [3:0]  r_inst, r_count;
    logic [4:0]  r_slot;
    logic [1:0]  r_word;
    logic [9:0]  r_type_size;
    logic [31:0] r_id, r_start, r_end;

    logic        w_req, w_ack, w_err;
    logic [31:0] w_rdata;
    logic        w_table_end, w_match, w_hit, w_last_slot;

    pnp_apb_rd #(
        .TIMEOUT (TIMEOUT)
    ) u_apb_rd (
        .i_clk     (i_clk),
        .i_nrst    (i_nrst),
        .i_req     (w_req),
        .i_addr    (pnp_descr_addr(TABLE_BASE, r_slot, r_word)),
        .o_ack     (w_ack),
        .o_err     (w_err),
        .o_rdata   (w_rdata),
        .o_psel    (o_psel),
        .o_penable (o_penable),
        .o_paddr   (o_paddr),
        .i_pready  (i_pready),
        .i_prdata  (i_prdata),
        .i_pslverr (i_pslverr)
    );

    assign w_table_end = (r_type_size[9:8] == PNP_DESCR_INVALID) || (r_type_size[7:0] == 8'd0);
    assign w_match     = (r_id == {r_vid, r_did});
    assign w_hit       = w_match && (r_count == r_inst);
    assign w_last_slot = (r_slot == c_LAST_SLOT);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= PNP_SCAN_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        unique case (r_state)
            PNP_SCAN_IDLE:   if (i_start) w_next = PNP_SCAN_SETUP;
            PNP_SCAN_SETUP: begin
                w_req  = 1'b1;
                w_next = PNP_SCAN_ACCESS;
            end
            PNP_SCAN_ACCESS: begin
                w_req = 1'b1;
                if (w_ack) begin
                    if (w_err)              w_next = PNP_SCAN_DONE;
                    else if (r_word == 2'd3) w_next = PNP_SCAN_CHECK;
                    else                    w_next = PNP_SCAN_SETUP;
                end
            end
            PNP_SCAN_CHECK: begin
                if (w_table_end || w_hit || w_last_slot) w_next = PNP_SCAN_DONE;
                else                                     w_next = PNP_SCAN_SETUP;
            end
            PNP_SCAN_DONE:   w_next = PNP_SCAN_IDLE;
            default:         w_next = PNP_SCAN_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_vid        <= 16'd0;
            r_did        <= 16'd0;
            r_inst       <= 4'd0;
            r_count      <= 4'd0;
            r_slot       <= 5'd0;
            r_word       <= 2'd0;
            r_type_size  <= 10'd0;
            r_id         <= 32'd0;
            r_start      <= 32'd0;
            r_end        <= 32'd0;
            o_found      <= 1'b0;
            o_err        <= 1'b0;
            o_index      <= 5'd0;
            o_addr_start <= 32'd0;
            o_addr_end   <= 32'd0;
        end else if (r_state == PNP_SCAN_IDLE) begin
            if (i_start) begin
                r_vid   <= i_vid;
                r_did   <= i_did;
                r_inst  <= i_inst;
                r_count <= 4'd0;
                r_slot  <= 5'd0;
                r_word  <= 2'd0;
                o_found <= 1'b0;
                o_err   <= 1'b0;
            end
        end else if (r_state == PNP_SCAN_ACCESS) begin
            if (w_ack && w_err) begin
                o_err <= 1'b1;
            end else if (w_ack) begin
                // Word wraps 3 -> 0 so the next slot starts at its type word.
                r_word <= r_word + 2'd1;
                unique case ({r_word, 2'b00})
                    PNP_DESCR_OFF_TYPE:  r_type_size <= w_rdata[9:0];
                    PNP_DESCR_OFF_ID:    r_id        <= w_rdata;
                    PNP_DESCR_OFF_START: r_start     <= w_rdata;
                    PNP_DESCR_OFF_END:   r_end       <= w_rdata;
                    default: ;
                endcase
            end
        end else if (r_state == PNP_SCAN_CHECK) begin
            if (!w_table_end) begin
                if (w_hit) begin
                    o_found      <= 1'b1;
                    o_index      <= r_slot;
                    o_addr_start <= r_start;
                    o_addr_end   <= r_end;
                end else begin
                    if (w_match)      r_count <= r_count + 4'd1;
                    if (!w_last_slot) r_slot  <= r_slot + 5'd1;
                end
            end
        end
    end

    assign o_busy   = (r_state == PNP_SCAN_SETUP) || (r_state == PNP_SCAN_ACCESS) ||
                      (r_state == PNP_SCAN_CHECK);
    assign o_done   = (r_state == PNP_SCAN_DONE);
    assign o_pwrite = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pnp_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pnp_scanner                                                     |
// | Brief  : Scoreboard bench for pnp_scanner with an APB table slave model.    |
// |          Honours PNP_SCAN_TIMEOUT_EN for the stalled-slave scenario.        |
// | Rev    : 1.0  initial release                                               |
// +----------------------------------------------------------------------------+
module tb_pnp_scanner;

    localparam logic [31:0] c_BASE = 32'h000FF000;

    typedef struct {
        logic        found;
        logic        err;
        logic [4:0]  idx;
        logic [31:0] s;
        logic [31:0] e;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] vid = 16'd0, did = 16'd0;
    logic [3:0]  inst = 4'd0;
    logic        busy, done, found, err, psel, penable, pwrite;
    logic [4:0]  index;
    logic [31:0] addr_start, addr_end, paddr, prdata, off;
    logic        pready, pslverr;

    logic [31:0] mem [64];
    logic        stall = 1'b0, err_en = 1'b0;
    logic [31:0] err_addr = 32'd0;
    logic [31:0] last_addr = 32'd0;
    int          acc_total = 0;

    int   n_checks = 0, n_errors = 0;
    exp_t sb[$];
    exp_t mon_x;

    always #5 clk = ~clk;

    pnp_scanner #(
        .TIMEOUT (8)
    ) dut (
        .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_vid(vid), .i_did(did), .i_inst(inst),
        .o_busy(busy), .o_done(done), .o_found(found), .o_err(err), .o_index(index),
        .o_addr_start(addr_start), .o_addr_end(addr_end), .o_psel(psel), .o_penable(penable),
        .o_paddr(paddr), .o_pwrite(pwrite), .i_pready(pready), .i_prdata(prdata),
        .i_pslverr(pslverr)
    );

    // APB table slave, zero wait states unless stalled.
    assign off     = paddr - c_BASE;
    assign prdata  = mem[off[7:2]];
    assign pready  = !stall;
    assign pslverr = err_en && psel && penable && (paddr == err_addr);

    always @(posedge clk) begin
        if (psel && penable && pready) last_addr <= paddr;
        if (psel && penable) acc_total <= acc_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_x = sb.pop_front();
                check("sb_found", {31'd0, found}, {31'd0, mon_x.found});
                check("sb_err", {31'd0, err}, {31'd0, mon_x.err});
                check("sb_busy_in_done", {31'd0, busy}, 32'd0);
                if (mon_x.found) begin
                    check("sb_index", {27'd0, index}, {27'd0, mon_x.idx});
                    check("sb_addr_start", addr_start, mon_x.s);
                    check("sb_addr_end", addr_end, mon_x.e);
                end
            end
        end
    end

    task automatic fill_default();
        for (int s = 0; s < 16; s++) begin
            mem[s*4]     = {22'd0, 2'd1, 8'd16};
            mem[s*4 + 1] = {16'h0001, 16'h0100 + 16'(s)};
            mem[s*4 + 2] = 32'h8000_0000 + 32'(s) * 32'h1000;
            mem[s*4 + 3] = 32'h8000_0FFF + 32'(s) * 32'h1000;
        end
        for (int s = 64 - 16*4; s < 0; s++) mem[s] = 32'd0;
    endtask

    task automatic set_slot(input int s, input logic [15:0] v, input logic [15:0] d,
                            input logic [31:0] a0, input logic [31:0] a1);
        mem[s*4 + 1] = {v, d};
        mem[s*4 + 2] = a0;
        mem[s*4 + 3] = a1;
    endtask

    function automatic exp_t model_scan(input logic [15:0] v, input logic [15:0] d,
                                        input logic [3:0] n);
        exp_t r;
        int   cnt;
        logic [31:0] w0;
        r = '{found: 1'b0, err: 1'b0, idx: 5'd0, s: 32'd0, e: 32'd0};
        cnt = 0;
        for (int s = 0; s < 16; s++) begin
            w0 = mem[s*4];
            if (w0[9:8] == 2'd0 || w0[7:0] == 8'd0) break;
            if (mem[s*4 + 1] == {v, d}) begin
                if (cnt == int'(n)) begin
                    r.found = 1'b1;
                    r.idx   = 5'(s);
                    r.s     = mem[s*4 + 2];
                    r.e     = mem[s*4 + 3];
                    break;
                end
                cnt++;
            end
        end
        return r;
    endfunction

    task automatic run_scan(input exp_t x, input logic [15:0] v, input logic [15:0] d,
                            input logic [3:0] n, output int cycles);
        bit timed_out;
        sb.push_back(x);
        @(negedge clk);
        vid = v; did = d; inst = n; start = 1'b1;
        cycles = 1;
        @(posedge clk);
        #1 start = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cycles++;
            @(negedge clk);
            if (cycles == 2) begin
                check("busy_after_start", {31'd0, busy}, 32'd1);
                check("first_paddr", paddr, c_BASE);
            end
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
        end
        if (timed_out) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    exp_t x;
    int   cyc;
    int   acc0;
    bit   hit;

    initial begin
        fill_default();
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_psel", {31'd0, psel}, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_found", {31'd0, found}, 32'd0);
        check("rst_pwrite", {31'd0, pwrite}, 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Single match at slot 5
        set_slot(5, 16'h00F2, 16'h007A, 32'h1001_0000, 32'h1001_0FFF);
        x = model_scan(16'h00F2, 16'h007A, 4'd0);
        run_scan(x, 16'h00F2, 16'h007A, 4'd0, cyc);
        check("t1_latency", 32'(cyc), 32'd56);
        check("t1_index", {27'd0, index}, 32'd5);
        check("t1_start", addr_start, 32'h1001_0000);
        check("t1_end", addr_end, 32'h1001_0FFF);
        @(negedge clk);
        check("t1_done_one_cycle", {31'd0, done}, 32'd0);
        check("t1_found_hold", {31'd0, found}, 32'd1);

        // Two matches: slots 3 and 9
        fill_default();
        set_slot(3, 16'h00F2, 16'h007A, 32'h2000_0000, 32'h2000_00FF);
        set_slot(9, 16'h00F2, 16'h007A, 32'h2900_0000, 32'h2900_FFFF);
        x = model_scan(16'h00F2, 16'h007A, 4'd1);
        run_scan(x, 16'h00F2, 16'h007A, 4'd1, cyc);
        check("t2_index", {27'd0, index}, 32'd9);
        check("t2_start", addr_start, 32'h2900_0000);
        x = model_scan(16'h00F2, 16'h007A, 4'd0);
        run_scan(x, 16'h00F2, 16'h007A, 4'd0, cyc);
        check("t2_inst0_index", {27'd0, index}, 32'd3);
        x = model_scan(16'h00F2, 16'h007A, 4'd2);
        run_scan(x, 16'h00F2, 16'h007A, 4'd2, cyc);
        check("t2_miss_latency", 32'(cyc), 32'd146);
        check("t2_miss_found", {31'd0, found}, 32'd0);

        // Async reset during ACCESS of slot 7
        @(negedge clk);
        vid = 16'hDEAD; did = 16'hBEEF; inst = 4'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (psel && penable && paddr == c_BASE + 32'h70) begin
                hit = 1'b1;
                break;
            end
        end
        check("t5_reached_slot7", {31'd0, hit}, 32'd1);
        #1 nrst = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_psel", {31'd0, psel}, 32'd0);
        check("t5_penable", {31'd0, penable}, 32'd0);
        check("t5_paddr", paddr, 32'd0);
        check("t5_index", {27'd0, index}, 32'd0);
        check("t5_addr_start", addr_start, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        fill_default();
        set_slot(5, 16'h00F2, 16'h007A, 32'h1001_0000, 32'h1001_0FFF);
        x = model_scan(16'h00F2, 16'h007A, 4'd0);
        run_scan(x, 16'h00F2, 16'h007A, 4'd0, cyc);
        check("t5_rerun_latency", 32'(cyc), 32'd56);

        // Invalid descriptor type at slot 4 ends the table
        fill_default();
        mem[4*4] = {22'd0, 2'd0, 8'd16};
        set_slot(6, 16'h00F2, 16'h007A, 32'h3000_0000, 32'h3000_0FFF);
        x = model_scan(16'h00F2, 16'h007A, 4'd0);
        run_scan(x, 16'h00F2, 16'h007A, 4'd0, cyc);
        check("t3_last_read", last_addr, c_BASE + 32'h4C);
        check("t3_found", {31'd0, found}, 32'd0);

        // Slave error on slot 2, +0x8
        fill_default();
        set_slot(5, 16'h00F2, 16'h007A, 32'h1001_0000, 32'h1001_0FFF);
        err_en = 1'b1;
        err_addr = c_BASE + 32'h28;
        x = '{found: 1'b0, err: 1'b1, idx: 5'd0, s: 32'd0, e: 32'd0};
        run_scan(x, 16'h00F2, 16'h007A, 4'd0, cyc);
        check("t4_psel_in_done", {31'd0, psel}, 32'd0);
        @(negedge clk);
        check("t4_psel_after", {31'd0, psel}, 32'd0);
        check("t4_err_hold", {31'd0, err}, 32'd1);
        err_en = 1'b0;

        // Slave never ready
        stall = 1'b1;
`ifdef PNP_SCAN_TIMEOUT_EN
        acc0 = acc_total;
        x = '{found: 1'b0, err: 1'b1, idx: 5'd0, s: 32'd0, e: 32'd0};
        run_scan(x, 16'h00F2, 16'h007A, 4'd0, cyc);
        @(negedge clk);
        check("t6_access_cycles", 32'(acc_total - acc0), 32'd8);
        check("t6_psel_dropped", {31'd0, psel}, 32'd0);
`else
        @(negedge clk);
        vid = 16'h00F2; did = 16'h007A; inst = 4'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (1000) @(negedge clk);
        check("t6_psel_held", {31'd0, psel}, 32'd1);
        check("t6_busy_held", {31'd0, busy}, 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
`endif
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
